// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, MDU state encoding and helpers for alu_mdu
// Contents:
//   alu_op_t     5-bit ALU/MDU operation codes (codes 22..31 are undefined)
//   mdu_state_t  multiply/divide sequencer states {IDLE, CALC, FIX}
//   DIVZERO_LO   LO value written on divide by zero (slice to DATA_WIDTH)
//   is_mdu_op()  1 for the multi-cycle MULT/MULTU/DIV/DIVU ops
package alu_pkg;

   typedef enum logic [4:0] {
      OP_AND   = 5'd0,
      OP_OR    = 5'd1,
      OP_XOR   = 5'd2,
      OP_NOR   = 5'd3,
      OP_ADD   = 5'd4,
      OP_ADDU  = 5'd5,
      OP_SUB   = 5'd6,
      OP_SLT   = 5'd7,
      OP_SLTU  = 5'd8,
      OP_SLL   = 5'd9,
      OP_SRL   = 5'd10,
      OP_SRA   = 5'd11,
      OP_EQU   = 5'd12,
      OP_NEQ   = 5'd13,
      OP_MFHI  = 5'd14,
      OP_MFLO  = 5'd15,
      OP_MTHI  = 5'd16,
      OP_MTLO  = 5'd17,
      OP_MULT  = 5'd18,
      OP_MULTU = 5'd19,
      OP_DIV   = 5'd20,
      OP_DIVU  = 5'd21
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } mdu_state_t;

   localparam logic [63:0] DIVZERO_LO = 64'hFFFF_FFFF_FFFF_FFFF;

   function automatic logic is_mdu_op(input logic [4:0] code);
      return (code == OP_MULT) || (code == OP_MULTU) ||
             (code == OP_DIV)  || (code == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - radix-2 magnitude multiply / restoring divide datapath
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           load operands and clear the step counter
//   step            perform one radix-2 iteration this cycle
//   is_div          latched at start: 1 = divide, 0 = multiply
//   a_mag, b_mag    unsigned magnitudes (multiplicand/dividend, multiplier/divisor)
//   hi_mag, lo_mag  multiply: product high/low; divide: remainder/quotient
//   done            strobe on the final step (step with count == DATA_WIDTH-1)
module mdu_iter #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_W      = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  step,
   input  logic                  is_div,
   input  logic [DATA_WIDTH-1:0] a_mag,
   input  logic [DATA_WIDTH-1:0] b_mag,
   output logic [DATA_WIDTH-1:0] hi_mag,
   output logic [DATA_WIDTH-1:0] lo_mag,
   output logic                  done
);

   localparam int MSB = DATA_WIDTH - 1;

   // acc: product high half / partial remainder
   // quo: multiplier being shifted out / quotient being shifted in
   logic [MSB:0]     acc;
   logic [MSB:0]     quo;
   logic [MSB:0]     dvs;
   logic             div_mode;
   logic [CNT_W-1:0] cnt;

   logic [MSB:0]     addend;
   logic [DATA_WIDTH:0] add_sum;
   logic [DATA_WIDTH:0] shifted;
   logic [DATA_WIDTH:0] trial;

   always_comb begin
      addend  = quo[0] ? dvs : '0;
      add_sum = {1'b0, acc} + {1'b0, addend};
      shifted = {acc, quo[MSB]};
      // A borrow out of bit DATA_WIDTH means the divisor did not fit.
      trial   = shifted - {1'b0, dvs};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         quo      <= '0;
         dvs      <= '0;
         div_mode <= 1'b0;
         cnt      <= '0;
      end else if (start) begin
         acc      <= '0;
         quo      <= a_mag;
         dvs      <= b_mag;
         div_mode <= is_div;
         cnt      <= '0;
      end else if (step) begin
         cnt <= cnt + CNT_W'(1);
         if (div_mode) begin
            if (!trial[DATA_WIDTH]) begin
               acc <= trial[MSB:0];
               quo <= {quo[MSB-1:0], 1'b1};
            end else begin
               acc <= shifted[MSB:0];
               quo <= {quo[MSB-1:0], 1'b0};
            end
         end else begin
            acc <= add_sum[DATA_WIDTH:1];
            quo <= {add_sum[0], quo[MSB:1]};
         end
      end
   end

   assign hi_mag = acc;
   assign lo_mag = quo;
   assign done   = step && (cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - execute-stage ALU with iterative multiply/divide and HI/LO
// Optional build macro: ALU_OVERFLOW_TRAP_EN (signed ADD/SUB overflow flag on out_ovf).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             squash: abort MDU op, drop out_valid, block acceptance
//   in_valid/in_ready op handshake; accepted when both high
//   op                alu_op_t code
//   alu1, alu2        operand A (rs), operand B (rt/imm/shamt)
//   out_valid         one-cycle pulse per completed op
//   out_data          result (0 for MULT*/DIV*/MTHI/MTLO and undefined codes)
//   out_cmp           EQU/NEQ outcome
//   out_ovf           signed ADD/SUB overflow (constant 0 without the macro)
//   busy              MDU sequencing, equals !in_ready
module alu_mdu
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int SHAMT_W    = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4:0]            op,
   input  logic [DATA_WIDTH-1:0] alu1,
   input  logic [DATA_WIDTH-1:0] alu2,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_cmp,
   output logic                  out_ovf,
   output logic                  busy
);

   localparam int MSB = DATA_WIDTH - 1;

   mdu_state_t state, state_nx;

   logic [MSB:0] hi, lo;
   logic         accept;
   logic         mdu_start;
   logic         mdu_step;
   logic         mdu_done;
   logic         op_is_div;
   logic         op_signed;
   logic         a_neg, b_neg;
   logic [MSB:0] a_mag, b_mag;
   logic [MSB:0] hi_mag, lo_mag;

   logic [MSB:0]         sum, diff;
   logic [SHAMT_W-1:0]   shamt;
   logic [MSB:0]         res;
   logic                 cmp;

   logic                 is_div_r, neg_lo_r, neg_hi_r, div0_r;
   logic [MSB:0]         dividend_r;
   logic [2*DATA_WIDTH-1:0] prod_mag, prod_fix;
   logic [MSB:0]         hi_fix, lo_fix;

   logic                 out_valid_r;
   logic [MSB:0]         out_data_r;
   logic                 out_cmp_r;

   assign in_ready = (state == IDLE);
   assign busy     = !in_ready;
   assign accept   = in_valid && in_ready && !flush;

   // ---------------- single-cycle datapath ----------------
   assign sum   = alu1 + alu2;
   assign diff  = alu1 - alu2;
   assign shamt = alu2[SHAMT_W-1:0];

   always_comb begin
      res = '0;
      cmp = 1'b0;
      case (op)
         OP_AND:  res = alu1 & alu2;
         OP_OR:   res = alu1 | alu2;
         OP_XOR:  res = alu1 ^ alu2;
         OP_NOR:  res = ~(alu1 | alu2);
         OP_ADD,
         OP_ADDU: res = sum;
         OP_SUB:  res = diff;
         OP_SLT:  res = {{MSB{1'b0}}, ($signed(alu1) < $signed(alu2))};
         OP_SLTU: res = {{MSB{1'b0}}, (alu1 < alu2)};
         OP_SLL:  res = alu1 << shamt;
         OP_SRL:  res = alu1 >> shamt;
         OP_SRA:  res = DATA_WIDTH'($signed(alu1) >>> shamt);
         OP_EQU: begin
            cmp = (alu1 == alu2);
            res = {{MSB{1'b0}}, cmp};
         end
         OP_NEQ: begin
            cmp = (alu1 != alu2);
            res = {{MSB{1'b0}}, cmp};
         end
         OP_MFHI: res = hi;
         OP_MFLO: res = lo;
         default: res = '0;
      endcase
   end

   // ---------------- MDU sequencing ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      mdu_start = 1'b0;
      if (flush) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE: if (accept && is_mdu_op(op)) begin
               state_nx  = CALC;
               mdu_start = 1'b1;
            end
            CALC: if (mdu_done) state_nx = FIX;
            FIX:  state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   assign mdu_step  = (state == CALC);
   assign op_is_div = (op == OP_DIV) || (op == OP_DIVU);
   assign op_signed = (op == OP_MULT) || (op == OP_DIV);
   assign a_neg     = op_signed && alu1[MSB];
   assign b_neg     = op_signed && alu2[MSB];
   assign a_mag     = a_neg ? -alu1 : alu1;
   assign b_mag     = b_neg ? -alu2 : alu2;

   // Sign and special-case context captured at acceptance, applied in FIX.
   always_ff @(posedge clk) begin
      if (rst) begin
         is_div_r   <= 1'b0;
         neg_lo_r   <= 1'b0;
         neg_hi_r   <= 1'b0;
         div0_r     <= 1'b0;
         dividend_r <= '0;
      end else if (mdu_start) begin
         is_div_r   <= op_is_div;
         neg_lo_r   <= a_neg ^ b_neg;
         neg_hi_r   <= a_neg;
         div0_r     <= (alu2 == '0);
         dividend_r <= alu1;
      end
   end

   mdu_iter #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_W      (SHAMT_W)
   ) u_iter (
      .clk    (clk),
      .rst    (rst),
      .start  (mdu_start),
      .step   (mdu_step),
      .is_div (op_is_div),
      .a_mag  (a_mag),
      .b_mag  (b_mag),
      .hi_mag (hi_mag),
      .lo_mag (lo_mag),
      .done   (mdu_done)
   );

   assign prod_mag = {hi_mag, lo_mag};

   always_comb begin
      hi_fix   = '0;
      lo_fix   = '0;
      prod_fix = neg_lo_r ? -prod_mag : prod_mag;
      if (is_div_r) begin
         if (div0_r) begin
            lo_fix = DIVZERO_LO[MSB:0];
            hi_fix = dividend_r;
         end else begin
            // Most-negative / -1 falls out naturally: the magnitude quotient
            // 2^(W-1) negated wraps back to the most-negative value.
            lo_fix = neg_lo_r ? -lo_mag : lo_mag;
            hi_fix = neg_hi_r ? -hi_mag : hi_mag;
         end
      end else begin
         hi_fix = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
         lo_fix = prod_fix[MSB:0];
      end
   end

   // HI/LO: FIX results commit when FIX completes; a flush there discards them.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi <= '0;
         lo <= '0;
      end else if (!flush) begin
         if (state == FIX) begin
            hi <= hi_fix;
            lo <= lo_fix;
         end else if (accept && (op == OP_MTHI)) begin
            hi <= alu1;
         end else if (accept && (op == OP_MTLO)) begin
            lo <= alu1;
         end
      end
   end

   // ---------------- result registers ----------------
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_cmp_r   <= 1'b0;
      end else begin
         out_valid_r <= accept && !is_mdu_op(op);
         out_data_r  <= accept ? res : '0;
         out_cmp_r   <= accept && cmp;
      end
   end

   // The MDU completion pulse is the FIX cycle itself; out_data_r is 0 there
   // because nothing was accepted during CALC.
   assign out_valid = out_valid_r || (state == FIX);
   assign out_data  = out_data_r;
   assign out_cmp   = out_cmp_r;

`ifdef ALU_OVERFLOW_TRAP_EN
   logic ovf_nx;
   logic out_ovf_r;

   always_comb begin
      ovf_nx = 1'b0;
      if (op == OP_ADD)
         ovf_nx = (alu1[MSB] == alu2[MSB]) && (sum[MSB] != alu1[MSB]);
      else if (op == OP_SUB)
         ovf_nx = (alu1[MSB] != alu2[MSB]) && (diff[MSB] != alu1[MSB]);
   end

   always_ff @(posedge clk) begin
      if (rst || flush) out_ovf_r <= 1'b0;
      else              out_ovf_r <= accept && ovf_nx;
   end

   assign out_ovf = out_ovf_r;
`else
   assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - directed and randomized self-checking bench for alu_mdu
module tb_alu_mdu;
   import alu_pkg::*;

   localparam int DW = 32;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -SMAX - 1;
`ifdef ALU_OVERFLOW_TRAP_EN
   localparam logic OVF_EN = 1'b1;
`else
   localparam logic OVF_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, flush, in_valid;
   logic        in_ready, out_valid, out_cmp, out_ovf, busy;
   logic [4:0]  op;
   logic [31:0] alu1, alu2, out_data;

   always #5 clk = ~clk;

   alu_mdu #(.DATA_WIDTH(DW), .SHAMT_W(5)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .alu1(alu1), .alu2(alu2), .out_valid(out_valid), .out_data(out_data),
      .out_cmp(out_cmp), .out_ovf(out_ovf), .busy(busy)
   );

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   logic [31:0] m_hi = 0, m_lo = 0, pend_hi = 0, pend_lo = 0;
   int          busy_left = 0;
   logic        known = 1'b0;
   logic        e_valid = 1'b0, e_cmp = 1'b0, e_ovf = 1'b0, e_ready = 1'b1;
   logic [31:0] e_data = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic is_mdu(input logic [4:0] o);
      return o == OP_MULT || o == OP_MULTU || o == OP_DIV || o == OP_DIVU;
   endfunction

   function automatic void ref_mdu(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l);
      longint      p;
      logic [63:0] pu;
      int          q, r;
      h = 0;
      l = 0;
      case (o)
         OP_MULT: begin
            p = longint'($signed(a)) * longint'($signed(b));
            h = p[63:32];
            l = p[31:0];
         end
         OP_MULTU: begin
            pu = {32'd0, a} * {32'd0, b};
            h = pu[63:32];
            l = pu[31:0];
         end
         OP_DIV: begin
            if (b == 0) begin
               h = a; l = 32'hFFFFFFFF;
            end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
               h = 0; l = 32'h80000000;
            end else begin
               q = $signed(a) / $signed(b);
               r = $signed(a) % $signed(b);
               h = r; l = q;
            end
         end
         OP_DIVU: begin
            if (b == 0) begin
               h = a; l = 32'hFFFFFFFF;
            end else begin
               h = a % b; l = a / b;
            end
         end
         default: ;
      endcase
   endfunction

   function automatic void ref_single(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] hv, input logic [31:0] lv,
                                      output logic [31:0] d, output logic c, output logic ov);
      longint s;
      d = 0; c = 0; ov = 0;
      case (o)
         OP_AND:  d = a & b;
         OP_OR:   d = a | b;
         OP_XOR:  d = a ^ b;
         OP_NOR:  d = ~(a | b);
         OP_ADD: begin
            d = a + b;
            s = longint'($signed(a)) + longint'($signed(b));
            ov = OVF_EN && (s > SMAX || s < SMIN);
         end
         OP_ADDU: d = a + b;
         OP_SUB: begin
            d = a - b;
            s = longint'($signed(a)) - longint'($signed(b));
            ov = OVF_EN && (s > SMAX || s < SMIN);
         end
         OP_SLT:  d = ($signed(a) < $signed(b)) ? 1 : 0;
         OP_SLTU: d = (a < b) ? 1 : 0;
         OP_SLL:  d = a << b[4:0];
         OP_SRL:  d = a >> b[4:0];
         OP_SRA:  d = $signed(a) >>> b[4:0];
         OP_EQU: begin c = (a == b); d = {31'd0, c}; end
         OP_NEQ: begin c = (a != b); d = {31'd0, c}; end
         OP_MFHI: d = hv;
         OP_MFLO: d = lv;
         default: ;
      endcase
   endfunction

   // Model: advances once per rising edge using the inputs the DUT sampled.
   initial forever begin
      @(posedge clk);
      if (rst) begin
         m_hi = 0; m_lo = 0; busy_left = 0;
         e_valid = 0; e_data = 0; e_cmp = 0; e_ovf = 0; e_ready = 1; known = 1;
      end else if (known) begin
         if (busy_left > 0) begin
            if (flush) busy_left = 0;
            else begin
               if (busy_left == 1) begin m_hi = pend_hi; m_lo = pend_lo; end
               busy_left--;
            end
            e_valid = (busy_left == 1); e_data = 0; e_cmp = 0; e_ovf = 0;
            e_ready = (busy_left == 0);
         end else begin
            e_valid = 0; e_data = 0; e_cmp = 0; e_ovf = 0; e_ready = 1;
            if (!flush && in_valid) begin
               if (is_mdu(op)) begin
                  ref_mdu(op, alu1, alu2, pend_hi, pend_lo);
                  busy_left = DW + 1;
                  e_ready = 0;
               end else begin
                  ref_single(op, alu1, alu2, m_hi, m_lo, e_data, e_cmp, e_ovf);
                  e_valid = 1;
                  if (op == OP_MTHI) m_hi = alu1;
                  else if (op == OP_MTLO) m_lo = alu1;
               end
            end
         end
      end
   end

   // Compare process: every cycle once the model is synchronised.
   always @(negedge clk) begin
      if (known) begin
         chk("in_ready", {31'd0, in_ready}, {31'd0, e_ready});
         chk("busy", {31'd0, busy}, {31'd0, !e_ready});
         chk("out_valid", {31'd0, out_valid}, {31'd0, e_valid});
         if (e_valid && out_valid) begin
            chk("out_data", out_data, e_data);
            chk("out_cmp", {31'd0, out_cmp}, {31'd0, e_cmp});
            chk("out_ovf", {31'd0, out_ovf}, {31'd0, e_ovf});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int k = 0;
      while (!in_ready && k < 200) begin
         tick();
         k++;
      end
      if (!in_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_ready: in_ready still 0 after %0d cycles, required 1", k);
      end
   endtask

   task automatic exec(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] d);
      wait_ready();
      op = o; alu1 = a; alu2 = b; in_valid = 1;
      tick();
      in_valid = 0;
      d = out_data;
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         5: return $urandom_range(0, 40);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] d, d2, h, l;
      int lat, lowcnt, seen;
      rst = 1; flush = 0; in_valid = 0; op = 0; alu1 = 0; alu2 = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;

      // reset values
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_out_cmp", {31'd0, out_cmp}, 32'h0);
      chk("rst_out_ovf", {31'd0, out_ovf}, 32'h0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'h0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'h1);

      // pin the reference model with hand-computed values
      ref_mdu(OP_MULT, 32'hFFFFFFFD, 32'd7, h, l);
      chk("ref_mult_hi", h, 32'hFFFFFFFF);
      chk("ref_mult_lo", l, 32'hFFFFFFEB);
      ref_mdu(OP_DIV, 32'h80000000, 32'hFFFFFFFF, h, l);
      chk("ref_divmin_lo", l, 32'h80000000);
      chk("ref_divmin_hi", h, 32'h0);
      ref_mdu(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, h, l);
      chk("ref_multu_hi", h, 32'hFFFFFFFE);
      chk("ref_multu_lo", l, 32'h00000001);

      // ADD wrap and overflow flag
      exec(OP_ADD, 32'h7FFFFFFF, 32'h1, d);
      chk("add_wrap", d, 32'h80000000);
      chk("add_ovf", {31'd0, out_ovf}, {31'd0, OVF_EN});

      // back-to-back SLT / SLTU, EQU
      exec(OP_SLT, 32'hFFFFFFFF, 32'h1, d);
      exec(OP_SLTU, 32'hFFFFFFFF, 32'h1, d2);
      chk("slt_neg", d, 32'h1);
      chk("sltu_big", d2, 32'h0);
      exec(OP_EQU, 32'd5, 32'd5, d);
      chk("equ_cmp", {31'd0, out_cmp}, 32'h1);
      exec(OP_SRA, 32'h80000000, 32'd4, d);
      chk("sra", d, 32'hF8000000);
      exec(5'd30, 32'h1234, 32'h5678, d);
      chk("undef_valid", {31'd0, out_valid}, 32'h1);
      chk("undef_data", d, 32'h0);

      // MULT -3 x 7: latency and busy window
      exec(OP_MULT, 32'hFFFFFFFD, 32'd7, d);
      lat = 0; lowcnt = 0;
      for (int k = 1; k <= 60; k++) begin
         if (!in_ready) lowcnt++;
         if (out_valid && lat == 0) lat = k;
         tick();
      end
      chk("mult_latency", 32'(lat), 32'd33);
      chk("mult_busy_cycles", 32'(lowcnt), 32'd33);
      exec(OP_MFHI, 0, 0, d);
      chk("mult_hi", d, 32'hFFFFFFFF);
      exec(OP_MFLO, 0, 0, d);
      chk("mult_lo", d, 32'hFFFFFFEB);

      // DIV -7/2, DIVU 7/0
      exec(OP_DIV, 32'hFFFFFFF9, 32'd2, d);
      exec(OP_MFLO, 0, 0, d);
      chk("div_lo", d, 32'hFFFFFFFD);
      exec(OP_MFHI, 0, 0, d);
      chk("div_hi", d, 32'hFFFFFFFF);
      exec(OP_DIVU, 32'd7, 32'd0, d);
      exec(OP_MFLO, 0, 0, d);
      chk("div0_lo", d, 32'hFFFFFFFF);
      exec(OP_MFHI, 0, 0, d);
      chk("div0_hi", d, 32'd7);

      // flush mid-DIVU keeps HI
      exec(OP_MTHI, 32'hAA, 0, d);
      exec(OP_DIVU, 32'd9, 32'd4, d);
      repeat (9) tick();
      flush = 1;
      tick();
      flush = 0;
      chk("flush_ready", {31'd0, in_ready}, 32'h1);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         if (out_valid) seen++;
         tick();
      end
      chk("flush_no_valid", 32'(seen), 32'd0);
      exec(OP_MFHI, 0, 0, d);
      chk("flush_hi_kept", d, 32'hAA);

      // reset mid-MULTU
      exec(OP_MULTU, 32'h12345678, 32'h9ABCDEF0, d);
      repeat (10) tick();
      rst = 1;
      tick();
      rst = 0;
      chk("midrst_ready", {31'd0, in_ready}, 32'h1);
      chk("midrst_valid", {31'd0, out_valid}, 32'h0);
      chk("midrst_data", out_data, 32'h0);
      exec(OP_MFLO, 0, 0, d);
      chk("midrst_lo", d, 32'h0);

      // randomized traffic, checked by the compare process
      for (int c = 0; c < 3000; c++) begin
         int r, v;
         r = $urandom_range(0, 999);
         rst   = (r < 3);
         flush = (r >= 3 && r < 25);
         in_valid = ($urandom_range(0, 3) != 0);
         v = $urandom_range(0, 99);
         if (v < 8)       op = 5'(OP_MULT + $urandom_range(0, 3));
         else if (v < 11) op = 5'($urandom_range(22, 31));
         else             op = 5'($urandom_range(0, 17));
         alu1 = rand_operand();
         alu2 = rand_operand();
         tick();
      end
      rst = 0; flush = 0; in_valid = 0;
      repeat (40) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
